// File: rtl/fifo_axis_reader_if.sv
// Bundle between the upstream sync FIFO read port and the AXI-Stream master side.
interface fifo_axis_reader_if #(
  parameter int DWIDTH = 16
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DWIDTH-1:0] fifo_dout;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [1:0]        buf_count;

  modport master (
    input  fifo_empty, fifo_dout, m_axis_tready,
    output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, buf_count
  );

  modport slave (
    output fifo_empty, fifo_dout, m_axis_tready,
    input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, buf_count
  );
endinterface

// File: rtl/fifo_axis_reader.sv
// Drains a registered-output sync FIFO into an AXI-Stream master through a
// 3-entry skid buffer, with packet framing by a fixed beat count.
module fifo_axis_reader #(
  parameter int DWIDTH  = 16,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = $clog2(PKT_LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  fifo_axis_reader_if.master bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);

  logic [DWIDTH-1:0] ent_q [3];
  logic [DWIDTH-1:0] ent_d [3];
  logic [1:0]        count_q, count_d, wr_idx;
  logic              inflight_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pop;

  assign bus.m_axis_tvalid = (count_q != 2'd0);
  assign bus.m_axis_tdata  = ent_q[0];
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && (cnt_q == LAST);
  assign bus.buf_count     = count_q;
  assign pop               = bus.m_axis_tvalid && bus.m_axis_tready;

  // Credit: a read is only issued when its word is guaranteed a free slot.
  assign bus.fifo_rd_en = !rst && !bus.fifo_empty &&
                          (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);

  always_comb begin
    ent_d[0] = pop ? ent_q[1] : ent_q[0];
    ent_d[1] = pop ? ent_q[2] : ent_q[1];
    ent_d[2] = ent_q[2];
    wr_idx   = pop ? count_q - 2'd1 : count_q;
    for (int i = 0; i < 3; i++)
      if (inflight_q && (wr_idx == 2'(i))) ent_d[i] = bus.fifo_dout;
    count_d  = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q      <= '{default: '0};
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ent_q      <= ent_d;
      count_q    <= count_d;
      inflight_q <= bus.fifo_rd_en;
      if (pop) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed + randomized bench: queue model of the upstream FIFO and of the
// words owed downstream, checked every cycle.
module tb_fifo_axis_reader;
  localparam int DW  = 16;
  localparam int PKT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_axis_reader_if #(.DWIDTH(DW)) bus ();
  fifo_axis_reader #(.DWIDTH(DW), .PKT_LEN(PKT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, passed = 0;
  logic [DW-1:0] fifo_q[$];   // words still in the upstream FIFO
  logic [DW-1:0] exp_q[$];    // words read from the FIFO, not yet delivered
  int beat = 0, n_beats = 0, n_reads = 0, rd_prev = 0, stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  int k, flag;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(logic [DW-1:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    logic rd, hs;
    logic [DW-1:0] w;
    #1;
    rd = bus.fifo_rd_en;
    hs = bus.m_axis_tvalid && bus.m_axis_tready;
    w  = '0;
    if (rst) chk("rd_in_reset", rd, 0);
    else begin
      chk("rd_when_empty", rd && bus.fifo_empty, 0);
      chk("buf_count", bus.buf_count, exp_q.size() - rd_prev);
      chk("tvalid", bus.m_axis_tvalid, (exp_q.size() - rd_prev) != 0);
      if (!bus.m_axis_tvalid) chk("tlast_idle", bus.m_axis_tlast, 0);
      if (stall_prev != 0) begin
        chk("hold_data", bus.m_axis_tdata, prev_data);
        chk("hold_last", bus.m_axis_tlast, prev_last);
      end
      if (hs) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else chk("beat_data", bus.m_axis_tdata, exp_q.pop_front());
        chk("beat_last", bus.m_axis_tlast, (beat % PKT) == PKT - 1);
        beat++;
        n_beats++;
      end
      if (rd && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        exp_q.push_back(w);
        n_reads++;
      end
    end
    stall_prev = (!rst && bus.m_axis_tvalid && !bus.m_axis_tready) ? 1 : 0;
    prev_data  = bus.m_axis_tdata;
    prev_last  = bus.m_axis_tlast;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      beat = 0; rd_prev = 0; stall_prev = 0;
    end else begin
      rd_prev = rd ? 1 : 0;
      if (rd) bus.fifo_dout = w;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_q.delete();
    bus.fifo_empty = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    n_beats = 0;
    n_reads = 0;
  endtask

  task automatic run_beats(string tag, int target, int budget);
    int c = 0;
    while (n_beats < target && c < budget) begin
      cycle();
      c++;
    end
    chk(tag, n_beats, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.fifo_empty    = 1'b1;
    bus.fifo_dout     = '0;
    bus.m_axis_tready = 1'b0;
    repeat (2) cycle();
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_tlast", bus.m_axis_tlast, 0);
    chk("rst_buf_count", bus.buf_count, 0);
    chk("rst_tdata", bus.m_axis_tdata, 0);
    rst = 1'b0;

    // Three preloaded words, sink always ready: latency 2, then back-to-back.
    push(16'h00A1); push(16'h00B2); push(16'h00C3);
    bus.m_axis_tready = 1'b1;
    #1;
    chk("t1_rd_c0", bus.fifo_rd_en, 1);
    cycle(); chk("t1_tvalid_c1", bus.m_axis_tvalid, 0);
    cycle(); chk("t1_tvalid_c2", bus.m_axis_tvalid, 1);
             chk("t1_data_c2", bus.m_axis_tdata, 16'h00A1);
    cycle(); chk("t1_data_c3", bus.m_axis_tdata, 16'h00B2);
    cycle(); chk("t1_data_c4", bus.m_axis_tdata, 16'h00C3);
    cycle(); chk("t1_tvalid_c5", bus.m_axis_tvalid, 0);

    // Six words with the sink stalled: buffer fills to 3, then drains at full rate.
    do_reset();
    for (int i = 0; i < 6; i++) push(DW'(16'h0100 + i));
    bus.m_axis_tready = 1'b0;
    repeat (6) cycle();
    chk("t2_reads", n_reads, 3);
    chk("t2_rd_low", bus.fifo_rd_en, 0);
    chk("t2_buf_full", bus.buf_count, 3);
    chk("t2_head", bus.m_axis_tdata, 16'h0100);
    bus.m_axis_tready = 1'b1;
    n_beats = 0;
    repeat (6) cycle();
    chk("t2_back_to_back", n_beats, 6);

    // Two full packets contiguous, then two more with tready toggling.
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    run_beats("t3_beats", 8, 40);
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    n_beats = 0;
    k = 0;
    while (n_beats < 8 && k < 80) begin
      bus.m_axis_tready = (k % 2 == 0);
      cycle();
      k++;
    end
    chk("t4_beats", n_beats, 8);

    // Reset with two buffered and one in flight.
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(16'h0200 + i));
    bus.m_axis_tready = 1'b0;
    repeat (3) cycle();
    chk("t5_buf2", bus.buf_count, 2);
    rst = 1'b1;
    cycle();
    chk("t5_tvalid", bus.m_axis_tvalid, 0);
    chk("t5_rd", bus.fifo_rd_en, 0);
    chk("t5_buf0", bus.buf_count, 0);
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'(16'h0300 + i));
    bus.m_axis_tready = 1'b1;
    k = 0;
    while (!bus.m_axis_tvalid && k < 10) begin
      cycle();
      k++;
    end
    chk("t5_refill_valid", bus.m_axis_tvalid, 1);
    chk("t5_first_tlast", bus.m_axis_tlast, 0);
    chk("t5_first_data", bus.m_axis_tdata, 16'h0300);
    run_beats("t5_beats", 4, 20);

    // Empty FIFO for 20 cycles: nothing happens.
    do_reset();
    flag = 0;
    repeat (20) begin
      cycle();
      if (bus.fifo_rd_en || bus.m_axis_tvalid) flag = 1;
    end
    chk("t6_idle", flag, 0);

    // Random producer and sink.
    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) push(DW'($urandom));
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.m_axis_tready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.m_axis_tvalid) && k < 400) begin
      cycle();
      k++;
    end
    chk("t7_drained", exp_q.size() + fifo_q.size(), 0);
    chk("t7_idle", bus.m_axis_tvalid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
